icb_fetch_lsu_arb: RTL

- 2:1 ICB arbiter that shares one memory/icache ICB port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Tracks which requester owns each outstanding command and returns responses to that requester, in order.
- Sits between ifu/lsu and the BIU-side memory port.
- Replaces ad-hoc "LSU seizes bus" handling with an explicit grant.

---
 rtl/icb_arb_pkg.sv | 19 +
 rtl/icb_arb_owner_fifo.sv | 76 +++++++
 rtl/icb_fetch_lsu_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/icb_arb_pkg.sv
// ---------------------------------------------------------------------------
// icb_arb_pkg
// Shared types and default sizes for the IFU/LSU ICB arbiter.
//   owner_e      : owner ID carried with each outstanding command
//                  (OWN_IFU = 0, OWN_LSU = 1)
//   ICB_*_DEF    : default address/data width and outstanding depth
// ---------------------------------------------------------------------------
package icb_arb_pkg;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam int ICB_AW_DEF   = 64;
   localparam int ICB_DW_DEF   = 64;
   localparam int ICB_OUTS_DEF = 4;

endpackage

// File: rtl/icb_arb_owner_fifo.sv
// ---------------------------------------------------------------------------
// icb_arb_owner_fifo
// Records the owner of every accepted command, oldest first.
//   clk, rst     : clock, synchronous active-high reset
//   push         : append push_owner (ignored when full)
//   push_owner   : owner of the command being accepted
//   pop          : drop the head entry (ignored when empty)
//   head_owner   : owner of the oldest outstanding command
//   count        : number of outstanding entries (0..DEPTH)
//   empty, full  : status flags derived from count
// DEPTH must be a power of two so the pointers wrap for free.
// ---------------------------------------------------------------------------
module icb_arb_owner_fifo
   import icb_arb_pkg::*;
#(
   parameter  int DEPTH = ICB_OUTS_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  owner_e        push_owner,
   input  logic          pop,
   output owner_e        head_owner,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   // Entries are tiny and the head must be visible in the same cycle as the
   // memory response, so storage is a distributed array read asynchronously.
   owner_e        entry_reg [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   logic push_ok;
   logic pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   assign head_owner = entry_reg[rd_ptr_reg];
   assign count      = count_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         entry_reg[wr_ptr_reg] <= push_owner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         // Simultaneous push and pop leaves the count unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/icb_fetch_lsu_arb.sv
// ---------------------------------------------------------------------------
// icb_fetch_lsu_arb
// 2:1 ICB arbiter sharing one memory port between the IFU and the LSU.
// Commands are granted combinationally; the owner of every accepted command
// is queued so responses are routed back to the right requester, in order.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ifu_cmd_*  / ifu_rsp_*       : fetch command / response (IFU always ready)
//   lsu_cmd_*  / lsu_rsp_*       : load/store command / response
//   mem_cmd_*  / mem_rsp_*       : shared memory-side ICB port
//   arb_outs_cnt                 : number of outstanding commands
//   arb_orphan_err               : sticky, response seen with nothing pending
//
// Build option:
//   ICB_ARB_RR_EN defined   -> round-robin between simultaneous requesters
//                              (LSU wins the first tie after reset)
//   ICB_ARB_RR_EN undefined -> fixed priority, LSU over IFU
// ---------------------------------------------------------------------------
module icb_fetch_lsu_arb
   import icb_arb_pkg::*;
#(
   parameter  int AW         = ICB_AW_DEF,
   parameter  int DW         = ICB_DW_DEF,
   parameter  int OUTS_DEPTH = ICB_OUTS_DEF,
   localparam int CW         = $clog2(OUTS_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            ifu_cmd_valid,
   output logic            ifu_cmd_ready,
   input  logic [AW-1:0]   ifu_cmd_addr,
   output logic            ifu_rsp_valid,
   output logic [DW-1:0]   ifu_rsp_rdata,
   output logic            ifu_rsp_err,

   input  logic            lsu_cmd_valid,
   output logic            lsu_cmd_ready,
   input  logic [AW-1:0]   lsu_cmd_addr,
   input  logic            lsu_cmd_read,
   input  logic [DW-1:0]   lsu_cmd_wdata,
   input  logic [DW/8-1:0] lsu_cmd_wmask,
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [DW-1:0]   lsu_rsp_rdata,
   output logic            lsu_rsp_err,

   output logic            mem_cmd_valid,
   input  logic            mem_cmd_ready,
   output logic [AW-1:0]   mem_cmd_addr,
   output logic            mem_cmd_read,
   output logic [DW-1:0]   mem_cmd_wdata,
   output logic [DW/8-1:0] mem_cmd_wmask,
   input  logic            mem_rsp_valid,
   output logic            mem_rsp_ready,
   input  logic [DW-1:0]   mem_rsp_rdata,
   input  logic            mem_rsp_err,

   output logic [CW-1:0]   arb_outs_cnt,
   output logic            arb_orphan_err
);

   // ------------------------------------------------------------------
   // Owner FIFO
   // ------------------------------------------------------------------
   owner_e head_owner;
   logic   fifo_empty;
   logic   cmd_full;
   logic   cmd_accept;
   logic   rsp_pop;
   owner_e gnt_owner;

   icb_arb_owner_fifo #(
      .DEPTH      (OUTS_DEPTH)
   ) u_owner_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (cmd_accept),
      .push_owner (gnt_owner),
      .pop        (rsp_pop),
      .head_owner (head_owner),
      .count      (arb_outs_cnt),
      .empty      (fifo_empty),
      .full       (cmd_full)
   );

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
   logic   lock_reg;
   owner_e grant_reg;
   owner_e arb_owner;
   logic   lock_hold;

`ifdef ICB_ARB_RR_EN
   owner_e last_reg;

   always_comb begin
      arb_owner = OWN_IFU;
      if (ifu_cmd_valid && lsu_cmd_valid) begin
         // Tie goes to whoever was not served last.
         arb_owner = (last_reg == OWN_LSU) ? OWN_IFU : OWN_LSU;
      end else if (lsu_cmd_valid) begin
         arb_owner = OWN_LSU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg <= OWN_IFU;
      end else if (cmd_accept) begin
         last_reg <= gnt_owner;
      end
   end
`else
   always_comb begin
      arb_owner = lsu_cmd_valid ? OWN_LSU : OWN_IFU;
   end
`endif

   // A command presented but stalled by memory keeps its grant for as long
   // as its requester keeps valid high, so a presented request is never
   // swapped out from under the memory side.
   assign lock_hold = lock_reg &&
                      ((grant_reg == OWN_LSU) ? lsu_cmd_valid : ifu_cmd_valid);
   assign gnt_owner = lock_hold ? grant_reg : arb_owner;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_reg  <= 1'b0;
         grant_reg <= OWN_IFU;
      end else begin
         lock_reg  <= mem_cmd_valid & ~mem_cmd_ready;
         grant_reg <= gnt_owner;
      end
   end

   // ------------------------------------------------------------------
   // Command path
   // ------------------------------------------------------------------
   assign mem_cmd_valid = ~cmd_full & (ifu_cmd_valid | lsu_cmd_valid);
   assign cmd_accept    = mem_cmd_valid & mem_cmd_ready;

   always_comb begin
      mem_cmd_addr  = ifu_cmd_addr;
      mem_cmd_read  = 1'b1;
      mem_cmd_wdata = '0;
      mem_cmd_wmask = '1;
      if (gnt_owner == OWN_LSU) begin
         mem_cmd_addr  = lsu_cmd_addr;
         mem_cmd_read  = lsu_cmd_read;
         mem_cmd_wdata = lsu_cmd_wdata;
         mem_cmd_wmask = lsu_cmd_wmask;
      end
   end

   assign ifu_cmd_ready = (gnt_owner == OWN_IFU) & ifu_cmd_valid &
                          mem_cmd_ready & ~cmd_full;
   assign lsu_cmd_ready = (gnt_owner == OWN_LSU) & lsu_cmd_valid &
                          mem_cmd_ready & ~cmd_full;

   // ------------------------------------------------------------------
   // Response path
   // ------------------------------------------------------------------
   always_comb begin
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      mem_rsp_ready = 1'b1;    // empty FIFO: swallow orphan responses
      if (!fifo_empty) begin
         if (head_owner == OWN_LSU) begin
            lsu_rsp_valid = mem_rsp_valid;
            mem_rsp_ready = lsu_rsp_ready;
         end else begin
            ifu_rsp_valid = mem_rsp_valid;
         end
      end
   end

   assign rsp_pop       = mem_rsp_valid & mem_rsp_ready & ~fifo_empty;
   assign ifu_rsp_rdata = mem_rsp_rdata;
   assign ifu_rsp_err   = mem_rsp_err;
   assign lsu_rsp_rdata = mem_rsp_rdata;
   assign lsu_rsp_err   = mem_rsp_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         arb_orphan_err <= 1'b0;
      end else if (mem_rsp_valid && fifo_empty) begin
         arb_orphan_err <= 1'b1;
      end
   end

endmodule
